// File: rtl/reg_file_pkg.sv
// Shared LEGv8 datapath constants and types used by the register file and
// the decode logic that will index it.
package reg_file_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam int XZR_IDX = 31;
  localparam int LR_IDX  = 30;
  localparam int SP_IDX  = 28;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] dword_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: zero-register masking and optional
// same-cycle forwarding of the in-flight write.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int ZERO_REG = reg_file_pkg::XZR_IDX,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_mem,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rst_n,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic is_zero;
  logic fwd_hit;

  assign is_zero = (rd_idx == ZERO_IDX);
  // Forwarding is held off during reset so the port shows stored state only.
  assign fwd_hit = (BYPASS != 0) && rst_n && wr_en && (wr_idx == rd_idx);

  always_comb begin
    rd_data = rd_mem;
    if (is_zero) begin
      rd_data = '0;
    end else if (fwd_hit) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports, one
// synchronous write port, X31 reads as zero.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
  parameter int ZERO_REG = reg_file_pkg::XZR_IDX,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic wr_hit;

      // The zero register never accepts a write, so its entry stays cleared.
      assign wr_hit = reg_write && (write_reg == ADDR_W'(gi)) && (gi != ZERO_REG);

      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (wr_hit) begin
          mem_d[gi] = write_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port1 (
    .rd_idx (read_reg1),
    .rd_mem (mem_q[read_reg1]),
    .wr_idx (write_reg),
    .wr_data(write_data),
    .wr_en  (reg_write),
    .rst_n  (rst_n),
    .rd_data(read_data1)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port2 (
    .rd_idx (read_reg2),
    .rd_mem (mem_q[read_reg2]),
    .wr_idx (write_reg),
    .wr_data(write_data),
    .wr_en  (reg_write),
    .rst_n  (rst_n),
    .rd_data(read_data2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: one instance with forwarding, one without,
// driven by the same stimulus and checked against an array model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [63:0] write_data;
  logic        reg_write;
  logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

  logic [63:0] model [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file #(.BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_b), .read_data2(rd2_b)
  );

  reg_file #(.BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_n), .read_data2(rd2_n)
  );

  // Advance one rising edge, apply architectural effect to the model,
  // and return on the falling edge ready for new stimulus.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else if (reg_write && write_reg != 5'd31) begin
      model[write_reg] = write_data;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reg_write = 1'b1; write_reg = 5'd4; write_data = {$urandom, $urandom};
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    tick();
    rst_n = 1'b1; reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      #1;
      checks++;
      if (rd1_b !== 64'h0 || rd2_b !== 64'h0 || rd1_n !== 64'h0 || rd2_n !== 64'h0) begin
        errors++;
        $display("FAIL reset_read idx=%0d got b=%h/%h n=%h/%h want 0", i, rd1_b, rd2_b, rd1_n, rd2_n);
      end
    end
    $display("test_reset: 32 indices read after reset");
  endtask

  task automatic test_write_read();
    reg_write = 1'b1; write_reg = 5'd5; write_data = 64'hDEAD_BEEF_0123_4567;
    read_reg1 = 5'd0; read_reg2 = 5'd1;
    tick();
    reg_write = 1'b0; read_reg1 = 5'd5; read_reg2 = 5'd5;
    #1;
    checks++;
    if (rd1_b !== 64'hDEAD_BEEF_0123_4567 || rd2_b !== 64'hDEAD_BEEF_0123_4567 ||
        rd1_n !== 64'hDEAD_BEEF_0123_4567 || rd2_n !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL write_read_x5 got b=%h/%h n=%h/%h want deadbeef01234567", rd1_b, rd2_b, rd1_n, rd2_n);
    end
    $display("test_write_read: X5 written and read on both ports");
  endtask

  task automatic test_xzr();
    reg_write = 1'b1; write_reg = 5'd31; write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    read_reg1 = 5'd31; read_reg2 = 5'd31;
    #1;
    checks++;
    if (rd1_b !== 64'h0 || rd2_b !== 64'h0 || rd1_n !== 64'h0 || rd2_n !== 64'h0) begin
      errors++;
      $display("FAIL xzr_forward got b=%h/%h n=%h/%h want 0", rd1_b, rd2_b, rd1_n, rd2_n);
    end
    tick();
    reg_write = 1'b0;
    #1;
    checks++;
    if (rd2_b !== 64'h0 || rd2_n !== 64'h0) begin
      errors++;
      $display("FAIL xzr_after_write got b=%h n=%h want 0", rd2_b, rd2_n);
    end
    $display("test_xzr: write to X31 dropped");
  endtask

  task automatic test_bypass();
    reg_write = 1'b1; write_reg = 5'd7; write_data = 64'h1234;
    read_reg1 = 5'd7; read_reg2 = 5'd7;
    #1;
    checks++;
    if (rd1_b !== 64'h1234 || rd2_b !== 64'h1234) begin
      errors++;
      $display("FAIL bypass_on_same_cycle got %h/%h want 1234", rd1_b, rd2_b);
    end
    checks++;
    if (rd1_n !== 64'h0 || rd2_n !== 64'h0) begin
      errors++;
      $display("FAIL bypass_off_same_cycle got %h/%h want 0", rd1_n, rd2_n);
    end
    tick();
    reg_write = 1'b0;
    #1;
    checks++;
    if (rd1_n !== 64'h1234 || rd1_b !== 64'h1234) begin
      errors++;
      $display("FAIL bypass_after_edge got n=%h b=%h want 1234", rd1_n, rd1_b);
    end
    $display("test_bypass: X7 forwarding with and without bypass");
  endtask

  task automatic test_no_write();
    reg_write = 1'b1; write_reg = 5'd9; write_data = 64'hA;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    tick();
    reg_write = 1'b0; write_reg = 5'd9; write_data = 64'hB; read_reg1 = 5'd9; read_reg2 = 5'd9;
    #1;
    checks++;
    if (rd1_b !== 64'hA || rd2_n !== 64'hA) begin
      errors++;
      $display("FAIL no_write_before got b=%h n=%h want a", rd1_b, rd2_n);
    end
    tick();
    #1;
    checks++;
    if (rd1_b !== 64'hA || rd1_n !== 64'hA) begin
      errors++;
      $display("FAIL no_write_after got b=%h n=%h want a", rd1_b, rd1_n);
    end
    $display("test_no_write: reg_write=0 leaves X9 intact");
  endtask

  task automatic test_reset_mid();
    reg_write = 1'b1; write_reg = 5'd3; write_data = 64'h55;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    tick();
    rst_n = 1'b0; reg_write = 1'b1; write_reg = 5'd3; write_data = 64'h77;
    read_reg1 = 5'd3; read_reg2 = 5'd3;
    #1;
    checks++;
    if (rd1_b !== 64'h55 || rd2_b !== 64'h55 || rd1_n !== 64'h55) begin
      errors++;
      $display("FAIL reset_no_forward got b=%h/%h n=%h want 55", rd1_b, rd2_b, rd1_n);
    end
    tick();
    #1;
    checks++;
    if (rd1_b !== 64'h0 || rd2_b !== 64'h0 || rd1_n !== 64'h0 || rd2_n !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid_cleared got b=%h/%h n=%h/%h want 0", rd1_b, rd2_b, rd1_n, rd2_n);
    end
    rst_n = 1'b1; reg_write = 1'b0;
    tick();
    #1;
    checks++;
    if (rd1_b !== 64'h0 || rd2_n !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid_after got b=%h n=%h want 0", rd1_b, rd2_n);
    end
    $display("test_reset_mid: write coincident with reset lost");
  endtask

  task automatic test_random();
    logic [63:0] e1_b, e2_b, e1_n, e2_n;
    int fw1, fw2;
    for (int n = 0; n < 400; n++) begin
      rst_n      = ($urandom_range(0, 59) != 0);
      reg_write  = $urandom_range(0, 1) == 1;
      write_reg  = 5'($urandom);
      write_data = {$urandom, $urandom};
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom);
      read_reg2  = ($urandom_range(0, 4) == 0) ? read_reg1 : 5'($urandom);
      #1;
      fw1 = (rst_n && reg_write && write_reg == read_reg1) ? 1 : 0;
      fw2 = (rst_n && reg_write && write_reg == read_reg2) ? 1 : 0;
      e1_n = (read_reg1 == 5'd31) ? 64'h0 : model[read_reg1];
      e2_n = (read_reg2 == 5'd31) ? 64'h0 : model[read_reg2];
      e1_b = (read_reg1 != 5'd31 && fw1 == 1) ? write_data : e1_n;
      e2_b = (read_reg2 != 5'd31 && fw2 == 1) ? write_data : e2_n;
      checks++;
      if (rd1_b !== e1_b || rd2_b !== e2_b || rd1_n !== e1_n || rd2_n !== e2_n) begin
        errors++;
        $display("FAIL random n=%0d r1=%0d r2=%0d w=%0d we=%b rst_n=%b got b=%h/%h n=%h/%h want b=%h/%h n=%h/%h",
                 n, read_reg1, read_reg2, write_reg, reg_write, rst_n,
                 rd1_b, rd2_b, rd1_n, rd2_n, e1_b, e2_b, e1_n, e2_n);
      end
      tick();
    end
    $display("test_random: 400 randomized cycles");
  endtask

  initial begin
    rst_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_xzr();
    test_bypass();
    test_no_write();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
